// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, big-endian
// byte-lane enables and writeback source selects.
package mem_stage_pkg;

  typedef enum logic {StIdle, StBeat1} state_e;

  localparam logic [3:0] BeNone  = 4'b0000;
  localparam logic [3:0] BeLane0 = 4'b1000;
  localparam logic [3:0] BeLane1 = 4'b0100;
  localparam logic [3:0] BeLane2 = 4'b0010;
  localparam logic [3:0] BeLane3 = 4'b0001;
  localparam logic [3:0] BeAll   = 4'b1111;

  typedef enum logic [1:0] {WbLoad, WbLo, WbHi, WbResult} wb_sel_e;

  // Big-endian: address offset 0 lives in bits [31:24].
  function automatic logic [3:0] byte_lane_be(input logic [1:0] lane);
    logic [3:0] be;
    unique case (lane)
      2'd0:    be = BeLane0;
      2'd1:    be = BeLane1;
      2'd2:    be = BeLane2;
      default: be = BeLane3;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align_unit.sv
// Extracts and sign-extends load data from the 32-bit bus; a double is the
// buffered first beat followed by the current beat.
module load_align_unit (
  input  logic [31:0] rdata_i,
  input  logic [31:0] first_beat_i,
  input  logic [1:0]  lane_i,
  input  logic        byte_i,
  input  logic        double_i,
  output logic [63:0] load_o
);

  logic [7:0] lane_byte;

  always_comb begin
    unique case (lane_i)
      2'd0:    lane_byte = rdata_i[31:24];
      2'd1:    lane_byte = rdata_i[23:16];
      2'd2:    lane_byte = rdata_i[15:8];
      default: lane_byte = rdata_i[7:0];
    endcase
    if (byte_i) begin
      load_o = {{56{lane_byte[7]}}, lane_byte};
    end else if (double_i) begin
      load_o = {first_beat_i, rdata_i};
    end else begin
      load_o = {{32{rdata_i[31]}}, rdata_i};
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory access over a 32-bit req/ack port (doubles in two
// beats), Lo/Hi registers and the MEM/WB pipeline register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       EXE_MEM_Result,
  input  logic [63:0]       EXE_MEM_Treg,
  input  logic [63:0]       EXE_MEM_FPTregData,
  input  logic [4:0]        EXE_MEM_DstReg,
  input  logic [4:0]        EXE_MEM_FP_DstReg,
  input  logic              EXE_MEM_MemRead,
  input  logic              EXE_MEM_MemWrite,
  input  logic              EXE_MEM_MemtoReg,
  input  logic              EXE_MEM_RegWrite,
  input  logic              EXE_MEM_Byte,
  input  logic              EXE_MEM_double,
  input  logic              EXE_MEM_FPLoadStore,
  input  logic              EXE_MEM_floatop,
  input  logic              EXE_MEM_LoHiWrite,
  input  logic              EXE_MEM_LoRead,
  input  logic              EXE_MEM_HiRead,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              MEM_Stall,
  output logic              MEM_Misalign,
  output logic [63:0]       MEM_WB_Data,
  output logic [4:0]        MEM_WB_DstReg,
  output logic [4:0]        MEM_WB_FP_DstReg,
  output logic              MEM_WB_RegWrite,
  output logic              MEM_WB_floatop,
  output logic              MEM_WB_double,
  output logic              MEM_WB_Valid
);

  state_e            state_q, state_d;
  logic [31:0]       beat0_q, beat0_d;
  logic [31:0]       lo_q, hi_q;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       store, load_val, wb_data;
  logic              is_double, aligned, mem_op, access, misalign;
  logic              req, last_beat;
  logic [3:0]        be;
  wb_sel_e           wb_sel;

  assign addr      = EXE_MEM_Result[ADDR_W-1:0];
  assign is_double = EXE_MEM_double & ~EXE_MEM_Byte;
  assign mem_op    = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  assign store     = EXE_MEM_FPLoadStore ? EXE_MEM_FPTregData : EXE_MEM_Treg;

  always_comb begin
    if (EXE_MEM_Byte)   aligned = 1'b1;
    else if (is_double) aligned = (addr[2:0] == 3'b000);
    else                aligned = (addr[1:0] == 2'b00);
  end

  assign access   = mem_op & aligned;
  assign misalign = mem_op & ~aligned;

  always_comb begin
    state_d   = state_q;
    beat0_d   = beat0_q;
    req       = 1'b0;
    last_beat = 1'b1;
    dmem_addr = addr;
    unique case (state_q)
      StIdle: begin
        req       = access;
        last_beat = ~is_double;
        if (req && dmem_ack && is_double) begin
          beat0_d = dmem_rdata;
          state_d = StBeat1;
        end
      end
      StBeat1: begin
        req       = 1'b1;
        dmem_addr = addr + ADDR_W'(4);
        if (dmem_ack) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    if (EXE_MEM_Byte)                        dmem_wdata = {4{store[7:0]}};
    else if (is_double && state_q == StIdle) dmem_wdata = store[63:32];
    else                                     dmem_wdata = store[31:0];
    be = EXE_MEM_Byte ? byte_lane_be(addr[1:0]) : BeAll;
  end

  // Gated with rst_n so the port goes quiet the instant reset asserts.
  assign dmem_req  = rst_n & req;
  assign dmem_be   = dmem_req ? be : BeNone;
  assign dmem_we   = EXE_MEM_MemWrite;
  assign MEM_Stall = dmem_req & ~(dmem_ack & last_beat);

  load_align_unit u_load_align (
    .rdata_i      (dmem_rdata),
    .first_beat_i (beat0_q),
    .lane_i       (addr[1:0]),
    .byte_i       (EXE_MEM_Byte),
    .double_i     (is_double),
    .load_o       (load_val)
  );

  always_comb begin
    if (EXE_MEM_MemRead && EXE_MEM_MemtoReg) wb_sel = WbLoad;
    else if (EXE_MEM_LoRead)                 wb_sel = WbLo;
    else if (EXE_MEM_HiRead)                 wb_sel = WbHi;
    else                                     wb_sel = WbResult;
    unique case (wb_sel)
      WbLoad:  wb_data = load_val;
      WbLo:    wb_data = {{32{lo_q[31]}}, lo_q};
      WbHi:    wb_data = {{32{hi_q[31]}}, hi_q};
      default: wb_data = EXE_MEM_Result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      beat0_q          <= '0;
      lo_q             <= '0;
      hi_q             <= '0;
      MEM_Misalign     <= 1'b0;
      MEM_WB_Data      <= '0;
      MEM_WB_DstReg    <= '0;
      MEM_WB_FP_DstReg <= '0;
      MEM_WB_RegWrite  <= 1'b0;
      MEM_WB_floatop   <= 1'b0;
      MEM_WB_double    <= 1'b0;
      MEM_WB_Valid     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat0_q      <= beat0_d;
      MEM_Misalign <= misalign;
      if (!MEM_Stall) begin
        MEM_WB_Data      <= wb_data;
        MEM_WB_DstReg    <= EXE_MEM_DstReg;
        MEM_WB_FP_DstReg <= EXE_MEM_FP_DstReg;
        MEM_WB_RegWrite  <= EXE_MEM_RegWrite & ~misalign;
        MEM_WB_floatop   <= EXE_MEM_floatop;
        MEM_WB_double    <= EXE_MEM_double;
        MEM_WB_Valid     <= 1'b1;
        if (EXE_MEM_LoHiWrite) begin
          hi_q <= EXE_MEM_Result[63:32];
          lo_q <= EXE_MEM_Result[31:0];
        end
      end else begin
        MEM_WB_Valid    <= 1'b0;
        MEM_WB_RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a byte-addressed memory and
// Lo/Hi reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] EXE_MEM_Result, EXE_MEM_Treg, EXE_MEM_FPTregData;
  logic [4:0]  EXE_MEM_DstReg, EXE_MEM_FP_DstReg;
  logic        EXE_MEM_MemRead, EXE_MEM_MemWrite, EXE_MEM_MemtoReg, EXE_MEM_RegWrite;
  logic        EXE_MEM_Byte, EXE_MEM_double, EXE_MEM_FPLoadStore, EXE_MEM_floatop;
  logic        EXE_MEM_LoHiWrite, EXE_MEM_LoRead, EXE_MEM_HiRead;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        MEM_Stall, MEM_Misalign;
  logic [63:0] MEM_WB_Data;
  logic [4:0]  MEM_WB_DstReg, MEM_WB_FP_DstReg;
  logic        MEM_WB_RegWrite, MEM_WB_floatop, MEM_WB_double, MEM_WB_Valid;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .EXE_MEM_Result(EXE_MEM_Result), .EXE_MEM_Treg(EXE_MEM_Treg),
    .EXE_MEM_FPTregData(EXE_MEM_FPTregData), .EXE_MEM_DstReg(EXE_MEM_DstReg),
    .EXE_MEM_FP_DstReg(EXE_MEM_FP_DstReg), .EXE_MEM_MemRead(EXE_MEM_MemRead),
    .EXE_MEM_MemWrite(EXE_MEM_MemWrite), .EXE_MEM_MemtoReg(EXE_MEM_MemtoReg),
    .EXE_MEM_RegWrite(EXE_MEM_RegWrite), .EXE_MEM_Byte(EXE_MEM_Byte),
    .EXE_MEM_double(EXE_MEM_double), .EXE_MEM_FPLoadStore(EXE_MEM_FPLoadStore),
    .EXE_MEM_floatop(EXE_MEM_floatop), .EXE_MEM_LoHiWrite(EXE_MEM_LoHiWrite),
    .EXE_MEM_LoRead(EXE_MEM_LoRead), .EXE_MEM_HiRead(EXE_MEM_HiRead),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .MEM_Stall(MEM_Stall), .MEM_Misalign(MEM_Misalign),
    .MEM_WB_Data(MEM_WB_Data), .MEM_WB_DstReg(MEM_WB_DstReg),
    .MEM_WB_FP_DstReg(MEM_WB_FP_DstReg), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_floatop(MEM_WB_floatop), .MEM_WB_double(MEM_WB_double),
    .MEM_WB_Valid(MEM_WB_Valid)
  );

  typedef struct {
    logic rd, wr, m2r, rw, byt, dbl, fp, flt, lhw, lor, hir;
    logic [63:0] result, treg, fpt;
    logic [4:0]  dst, fdst;
  } op_t;

  logic [7:0]  bmem [0:1023];
  logic [31:0] lo_m, hi_m;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int b;
    b = int'({a[9:2], 2'b00});
    return {bmem[b], bmem[b+1], bmem[b+2], bmem[b+3]};
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic op_t zero_op();
    op_t o;
    {o.rd, o.wr, o.m2r, o.rw, o.byt, o.dbl, o.fp, o.flt, o.lhw, o.lor, o.hir} = '0;
    o.result = '0; o.treg = '0; o.fpt = '0; o.dst = '0; o.fdst = '0;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k, sz;
    logic [9:0] a;
    o = zero_op();
    k = $urandom_range(0, 3);
    sz = $urandom_range(0, 2);
    o.rd = (k == 0);
    o.wr = (k == 1);
    o.byt = (sz == 0);
    o.dbl = (sz == 2);
    o.fp = 1'($urandom);
    o.flt = o.fp;
    o.m2r = o.rd & ($urandom_range(0, 3) != 0);
    o.rw = ~o.wr;
    o.lhw = 1'($urandom);
    o.lor = 1'($urandom);
    o.hir = 1'($urandom);
    a = 10'($urandom);
    if ($urandom_range(0, 3) != 0) a = o.dbl ? {a[9:3], 3'b0} : o.byt ? a : {a[9:2], 2'b0};
    o.result = {32'($urandom), 22'd0, a};
    o.treg = {32'($urandom), 32'($urandom)};
    o.fpt = {32'($urandom), 32'($urandom)};
    o.dst = 5'($urandom);
    o.fdst = 5'($urandom);
    return o;
  endfunction

  task automatic drive(input op_t o);
    EXE_MEM_MemRead = o.rd;  EXE_MEM_MemWrite = o.wr;  EXE_MEM_MemtoReg = o.m2r;
    EXE_MEM_RegWrite = o.rw; EXE_MEM_Byte = o.byt;     EXE_MEM_double = o.dbl;
    EXE_MEM_FPLoadStore = o.fp; EXE_MEM_floatop = o.flt; EXE_MEM_LoHiWrite = o.lhw;
    EXE_MEM_LoRead = o.lor;  EXE_MEM_HiRead = o.hir;   EXE_MEM_Result = o.result;
    EXE_MEM_Treg = o.treg;   EXE_MEM_FPTregData = o.fpt;
    EXE_MEM_DstReg = o.dst;  EXE_MEM_FP_DstReg = o.fdst;
  endtask

  // Called at posedge+1; returns at posedge+1 after the op retires into MEM/WB.
  task automatic do_op(input op_t o, input int fix_dly);
    logic [31:0] a, ba [2], bwd [2];
    logic [63:0] s, ld, exp_wb;
    logic [3:0]  bbe;
    logic        mis, sz_byte, sz_dbl, fin;
    int          nb, d, len;
    a = o.result[31:0];
    sz_byte = o.byt;
    sz_dbl = o.dbl & ~o.byt;
    s = o.fp ? o.fpt : o.treg;
    mis = (o.rd | o.wr) & (sz_byte ? 1'b0 : sz_dbl ? (a % 8 != 0) : (a % 4 != 0));
    nb = (!(o.rd | o.wr) || mis) ? 0 : (sz_dbl ? 2 : 1);
    ba[0] = a;
    ba[1] = a + 4;
    bbe = sz_byte ? (4'b1000 >> a[1:0]) : 4'hF;
    bwd[0] = sz_byte ? {4{s[7:0]}} : sz_dbl ? s[63:32] : s[31:0];
    bwd[1] = s[31:0];
    if (sz_byte) ld = {{56{bmem[a[9:0]][7]}}, bmem[a[9:0]]};
    else if (sz_dbl) ld = {mem_word(a), mem_word(a + 4)};
    else ld = sext32(mem_word(a));
    exp_wb = (o.rd & o.m2r) ? ld : o.lor ? sext32(lo_m) : o.hir ? sext32(hi_m) : o.result;
    drive(o);
    for (int i = 0; i < nb; i++) begin
      d = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 3);
      for (int w = 0; w <= d; w++) begin
        fin = (w == d) && (i == nb - 1);
        dmem_ack = (w == d);
        dmem_rdata = o.rd ? mem_word(ba[i]) : $urandom;
        #4;
        check_eq("req", 64'(dmem_req), 64'd1);
        check_eq("addr", 64'(dmem_addr), 64'(ba[i]));
        check_eq("be", 64'(dmem_be), 64'(bbe));
        check_eq("we", 64'(dmem_we), 64'(o.wr));
        if (o.wr) check_eq("wdata", 64'(dmem_wdata), 64'(bwd[i]));
        check_eq("stall", 64'(MEM_Stall), 64'(!fin));
        @(posedge clk);
        #1;
        if (!fin) check_eq("bubble", 64'({MEM_WB_Valid, MEM_WB_RegWrite}), 64'd0);
      end
    end
    if (nb == 0) begin
      dmem_ack = 1'b0;
      #4;
      check_eq("noreq", 64'(dmem_req), 64'd0);
      check_eq("nostall", 64'(MEM_Stall), 64'd0);
      @(posedge clk);
      #1;
    end
    dmem_ack = 1'b0;
    check_eq("valid", 64'(MEM_WB_Valid), 64'd1);
    check_eq("regwr", 64'(MEM_WB_RegWrite), 64'(o.rw & ~mis));
    check_eq("misalign", 64'(MEM_Misalign), 64'(mis));
    check_eq("dst", 64'({MEM_WB_DstReg, MEM_WB_FP_DstReg}), 64'({o.dst, o.fdst}));
    check_eq("flags", 64'({MEM_WB_floatop, MEM_WB_double}), 64'({o.flt, o.dbl}));
    if (!mis) check_eq("wbdata", MEM_WB_Data, exp_wb);
    if (!mis && o.wr) begin
      len = sz_byte ? 1 : sz_dbl ? 8 : 4;
      for (int k = 0; k < len; k++) bmem[int'(a[9:0]) + k] = 8'(s >> (8 * (len - 1 - k)));
    end
    if (o.lhw) begin
      hi_m = o.result[63:32];
      lo_m = o.result[31:0];
    end
  endtask

  initial begin
    op_t o;
    for (int i = 0; i < 1024; i++) bmem[i] = 8'($urandom);
    lo_m = '0;
    hi_m = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(zero_op());
    #1;
    check_eq("rst_valid", 64'(MEM_WB_Valid), 64'd0);
    check_eq("rst_data", MEM_WB_Data, 64'd0);
    check_eq("rst_req", 64'({dmem_req, MEM_Stall, MEM_Misalign}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lb 0x1002, zero-wait ack
    {bmem[0], bmem[1], bmem[2], bmem[3]} = 32'h1122F344;
    o = zero_op();
    o.rd = 1; o.m2r = 1; o.rw = 1; o.byt = 1; o.dst = 5'd3;
    o.result = 64'h1002;
    do_op(o, 0);
    // sw 0x2000, three wait cycles
    o = zero_op();
    o.wr = 1; o.result = 64'h2000; o.treg = 64'hDEADBEEF;
    do_op(o, 3);
    // FP double load 0x3008, one wait per beat
    {bmem[8], bmem[9], bmem[10], bmem[11]} = 32'hAAAA0001;
    {bmem[12], bmem[13], bmem[14], bmem[15]} = 32'h5555FFFF;
    o = zero_op();
    o.rd = 1; o.m2r = 1; o.rw = 1; o.dbl = 1; o.fp = 1; o.flt = 1; o.fdst = 5'd7;
    o.result = 64'h3008;
    do_op(o, 1);
    // misaligned lw
    o = zero_op();
    o.rd = 1; o.m2r = 1; o.rw = 1; o.result = 64'h4002;
    do_op(o, 0);
    // Lo/Hi write then reads
    o = zero_op();
    o.lhw = 1; o.result = 64'h00000007_80000000;
    do_op(o, 0);
    o = zero_op();
    o.lor = 1; o.rw = 1;
    do_op(o, 0);
    o = zero_op();
    o.hir = 1; o.rw = 1;
    do_op(o, 0);

    for (int n = 0; n < 300; n++) do_op(rand_op(), -1);

    // Reset in the middle of a double load.
    o = zero_op();
    o.rd = 1; o.m2r = 1; o.rw = 1; o.dbl = 1; o.result = 64'h10;
    drive(o);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h12345678;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    #2;
    check_eq("beat1_req", 64'({dmem_req, dmem_addr}), 64'({1'b1, 32'h14}));
    rst_n = 1'b0;
    #1;
    check_eq("rst_drop", 64'({dmem_req, MEM_Stall, dmem_be}), 64'd0);
    @(posedge clk);
    #1;
    check_eq("rst_wb", 64'({MEM_WB_Valid, MEM_WB_RegWrite}), 64'd0);
    drive(zero_op());
    lo_m = '0;
    hi_m = '0;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    #4;
    check_eq("stale_req", 64'({dmem_req, MEM_Stall}), 64'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    check_eq("stale_regwr", 64'(MEM_WB_RegWrite), 64'd0);
    o = zero_op();
    o.rd = 1; o.m2r = 1; o.rw = 1; o.result = 64'h40;
    do_op(o, 0);
    for (int n = 0; n < 50; n++) do_op(rand_op(), -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the MIPS pipeline, fed directly by the EXE/MEM pipeline register and producing the registered MEM/WB outputs.
- Performs data-memory loads and stores (byte, word, double) over a 32-bit req/ack memory port. A double is split into two beats.
- Holds the Lo/Hi register pair.
- Raises MEM_Stall while an access is outstanding; the EXE/MEM register and all earlier stages hold while it is high.

Parameters:
ADDR_W, 32, data-memory address width
DATA_W, 32, data-memory bus width (fixed at 32; a double is two beats)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
EXE_MEM_Result  in  64  ALU result; bits [ADDR_W-1:0] are the effective address
EXE_MEM_Treg  in  64  integer store data
EXE_MEM_FPTregData  in  64  FP store data
EXE_MEM_DstReg  in  5  integer destination register
EXE_MEM_FP_DstReg  in  5  FP destination register
EXE_MEM_MemRead, EXE_MEM_MemWrite, EXE_MEM_MemtoReg, EXE_MEM_RegWrite  in  1 each  control
EXE_MEM_Byte, EXE_MEM_double, EXE_MEM_FPLoadStore, EXE_MEM_floatop  in  1 each  access size / FP select
EXE_MEM_LoHiWrite, EXE_MEM_LoRead, EXE_MEM_HiRead  in  1 each  Lo/Hi control
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word or byte address
dmem_wdata  out  32  write data
dmem_be  out  4  byte enables, bit 3 = bits [31:24]
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  beat complete; may arrive in the same cycle as req
MEM_Stall  out  1  hold upstream
MEM_Misalign  out  1  one-cycle exception pulse
MEM_WB_Data  out  64  writeback data
MEM_WB_DstReg, MEM_WB_FP_DstReg  out  5 each  destination registers
MEM_WB_RegWrite, MEM_WB_floatop, MEM_WB_double, MEM_WB_Valid  out  1 each  writeback control

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE; Lo = Hi = 0; first-beat buffer = 0.
  - All MEM_WB_* outputs are 0 and MEM_Misalign = 0.
  - dmem_req, MEM_Stall and dmem_be are forced to 0 immediately.
  - Reset mid-access abandons the access with no retry; a late ack is ignored.
- access = (MemRead | MemWrite) & aligned.
- Alignment rules:
  - Byte: any address.
  - Word: addr[1:0] = 0.
  - Double: addr[2:0] = 0.
- States:
  - IDLE: the access, if any, is beat 0. dmem_req = access; dmem_addr = addr.
    - ack on a single access -> complete.
    - ack on a double -> latch dmem_rdata into the first-beat buffer; go to BEAT1.
  - BEAT1: dmem_req = 1; dmem_addr = addr + 4.
    - ack -> complete; return to IDLE.
- MEM_Stall = dmem_req & ~(dmem_ack & final beat). This is combinational. A zero-wait single access never stalls.
- Endianness is big-endian.
  - Byte lane for address a[1:0] = 0,1,2,3 maps to be = 1000, 0100, 0010, 0001.
  - A byte store replicates store[7:0] across all four lanes.
  - A word store drives be = 1111 with store[31:0].
  - A double store sends store[63:32] on beat 0 and store[31:0] on beat 1.
- Store source: FPLoadStore ? FPTregData : Treg.
- Load extension:
  - Byte: sign-extended to 64 bits.
  - Word: sign-extended to 64 bits.
  - Double: {beat0, beat1}.
- Writeback mux, in priority order:
  1. MemRead & MemtoReg -> load data.
  2. LoRead -> sign-extended Lo.
  3. HiRead -> sign-extended Hi.
  4. Otherwise -> Result.
- MEM_WB update: registered on each clock.
  - When MEM_Stall = 0: MEM_WB_* capture the current instruction and MEM_WB_Valid = 1. A non-memory op therefore has 1-cycle latency.
  - When MEM_Stall = 1: MEM_WB_Valid = 0 and MEM_WB_RegWrite = 0 (bubble).
- Lo/Hi:
  - Written on a non-stalled cycle with LoHiWrite: Hi = Result[63:32], Lo = Result[31:0].
  - LoHiWrite together with LoRead or HiRead in the same instruction returns the old value.
- Misaligned access:
  - No dmem_req is issued.
  - MEM_Misalign pulses for 1 cycle.
  - The MEM_WB entry is Valid with RegWrite = 0.
- dmem_we = MemWrite. A store produces a writeback entry with RegWrite as supplied by EXE/MEM (normally 0).

Decomposition:
- Package mem_stage_pkg holds:
  - the state enum (IDLE, BEAT1);
  - byte-lane enable constants;
  - WB source select codes.
- One combinational sub-module, load_align_unit: takes rdata, the first-beat buffer, addr[1:0], Byte and double, and produces the 64-bit extended load value.
- The FSM, Lo/Hi registers and the MEM_WB register live in the top module.

Test Plan:
- lb at 0x1002 with rdata = 0x1122F344 and same-cycle ack -> be = 0010, MEM_Stall never asserted; next cycle MEM_WB_Data = 0xFFFF_FFFF_FFFF_FFF3, Valid = 1.
- sw at 0x2000, Treg = 0xDEADBEEF, ack delayed 3 cycles -> req held 4 cycles, Stall = 1 for 3 cycles, 3 bubbles (Valid = 0), be = 1111, wdata = 0xDEADBEEF.
- FP double load at 0x3008 with rdata 0xAAAA0001 then 0x5555FFFF, each acked after 1 wait -> addresses 0x3008 then 0x300C; MEM_WB_Data = 0xAAAA00015555FFFF, floatop = 1.
- lw at 0x4002 -> no req; MEM_Misalign = 1 for one cycle; MEM_WB_RegWrite = 0.
- LoHiWrite with Result = 0x00000007_80000000, then LoRead -> MEM_WB_Data = 0xFFFFFFFF80000000; a following HiRead -> 0x7.
- rst_n low during BEAT1 -> req and stall drop immediately; after release, state = IDLE and a stale ack causes no write.
